// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the integer execute stage: base ALU
//                control codes, M-extension funct3 codes, FSM state encoding
//                and op-field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Op-field geometry
    localparam int OP_W    = 5;     // full op: {m_sel, code[3:0]}
    localparam int BASE_W  = 4;     // base ALU control code width
    localparam int F3_W    = 3;     // M-extension funct3 width
    localparam int STATE_W = 2;

    // Base ALU control codes (op[4] == 0)
    localparam logic [BASE_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [BASE_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [BASE_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [BASE_W-1:0] ALU_SRA  = 4'b0011;
    localparam logic [BASE_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [BASE_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [BASE_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [BASE_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [BASE_W-1:0] ALU_XOR  = 4'b1010;
    localparam logic [BASE_W-1:0] ALU_SLTU = 4'b1111;

    // M-extension funct3 codes (op[4] == 1)
    localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
    localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [F3_W-1:0] F3_REM    = 3'b110;
    localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

    // Execute-stage FSM states
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Shared iterative datapath for unsigned multiply (radix-2
//                shift-add) and unsigned restoring division. Operates on
//                operand magnitudes; sign handling lives in the caller.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                flush_i           - abort the running operation
//                start_i           - load operands and begin iterating
//                is_div_i          - 1 = divide, 0 = multiply
//                a_mag_i, b_mag_i  - multiplicand/dividend, multiplier/divisor
//                last_o            - the step taken on this edge is the final one
//                acc_next_o        - accumulator value after this step
//                                    MUL: full 2*XLEN product
//                                    DIV: {remainder, quotient}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_mag_i,
    input  logic [XLEN-1:0]   b_mag_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] acc_next_o
);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   md_q;     // multiplicand (MUL) or divisor (DIV)
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              div_q;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    // The add carry becomes the new MSB.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? md_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: shift {rem, dividend} left by one, trial-subtract the
    // divisor from the remainder; a non-negative difference yields quotient
    // bit 1 and replaces the remainder. Remainder < divisor always holds, so
    // the shifted remainder fits in XLEN+1 bits and diff[XLEN] is its sign.
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_qbit;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, md_q};
    assign div_qbit  = ~div_diff[XLEN];
    assign div_rem   = div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_next  = {div_rem, acc_q[XLEN-2:0], div_qbit};

    assign acc_next_o = div_q ? div_next : mul_next;
    assign last_o     = busy_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            md_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (flush_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            acc_q  <= {{XLEN{1'b0}}, a_mag_i};
            md_q   <= b_mag_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= is_div_i;
        end else if (busy_q) begin
            // Counter stops at XLEN once the final step retires.
            acc_q <= acc_next_o;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule : alu_muldiv_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Integer execute stage. Single-cycle base ALU ops plus
//                iterative RV-M multiply/divide, valid/ready on both sides.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                flush               - drop in-flight op / held result
//                in_valid, in_ready  - request handshake
//                op                  - op[4]=0: base code op[3:0]
//                                      op[4]=1: M funct3 op[2:0]
//                a, b                - operands
//                out_valid, out_ready- result handshake
//                result, zero, op_err- result, result==0, bad op code
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1,
    parameter int SHAMT_W  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            op_err
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t          state_q,  state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q,    err_d;
    logic [F3_W-1:0] f3_q,     f3_d;
    logic            negq_q,   negq_d;   // negate product / quotient
    logic            negr_q,   negr_d;   // negate remainder

    // ------------------------------------------------------------------
    // Base ALU
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    base_res;
    logic               base_err;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        base_err = 1'b0;
        case (op[BASE_W-1:0])
            ALU_AND:  base_res = a & b;
            ALU_OR:   base_res = a | b;
            ALU_ADD:  base_res = a + b;
            ALU_SUB:  base_res = a - b;
            ALU_XOR:  base_res = a ^ b;
            ALU_SLL:  base_res = a << shamt;
            ALU_SRL:  base_res = a >> shamt;
            ALU_SRA:  base_res = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            default:  base_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // M-extension operand preparation
    // ------------------------------------------------------------------
    logic [F3_W-1:0] f3;
    logic            is_div;
    logic            a_signed, b_signed;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_is_zero;
    logic            div_ovf;

    assign f3       = op[F3_W-1:0];
    assign is_div   = f3[2];
    // Signed divide ops have funct3[0]==0; for multiply only MULHU treats
    // rs1 as unsigned and only MUL/MULH treat rs2 as signed.
    assign a_signed = is_div ? ~f3[0] : (f3 != F3_MULHU);
    assign b_signed = is_div ? ~f3[0] : ((f3 == F3_MUL) || (f3 == F3_MULH));
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign a_mag    = sa ? (~a + XLEN'(1)) : a;
    assign b_mag    = sb ? (~b + XLEN'(1)) : b;
    assign b_is_zero = (b == '0);
    assign div_ovf   = ~f3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);

    // ------------------------------------------------------------------
    // Iterative datapath
    // ------------------------------------------------------------------
    logic              iter_start;
    logic              iter_last;
    logic [2*XLEN-1:0] acc_next;

    generate
        if (ENABLE_M != 0) begin : g_muldiv
            alu_muldiv_iter #(
                .XLEN  (XLEN),
                .CNT_W (CNT_W)
            ) u_iter (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (flush),
                .start_i    (iter_start),
                .is_div_i   (is_div),
                .a_mag_i    (a_mag),
                .b_mag_i    (b_mag),
                .last_o     (iter_last),
                .acc_next_o (acc_next)
            );
        end else begin : g_no_muldiv
            assign iter_last = 1'b0;
            assign acc_next  = '0;
        end
    endgenerate

    // Sign fixup applied to the value produced by the final iteration, so
    // the result register loads on the same edge the last step completes.
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   mul_res, div_res;

    assign prod_signed = negq_q ? (~acc_next + (2*XLEN)'(1)) : acc_next;
    assign mul_res     = (f3_q == F3_MUL) ? prod_signed[XLEN-1:0]
                                          : prod_signed[2*XLEN-1:XLEN];
    assign quot        = acc_next[XLEN-1:0];
    assign rem         = acc_next[2*XLEN-1:XLEN];
    assign div_res     = f3_q[1] ? (negr_q ? (~rem  + XLEN'(1)) : rem)
                                 : (negq_q ? (~quot + XLEN'(1)) : quot);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        err_d      = err_q;
        f3_d       = f3_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        iter_start = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!op[OP_W-1]) begin
                            result_d = base_res;
                            err_d    = base_err;
                            state_d  = ST_DONE;
                        end else if (ENABLE_M == 0) begin
                            result_d = '0;
                            err_d    = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            err_d  = 1'b0;
                            f3_d   = f3;
                            negq_d = sa ^ sb;
                            negr_d = sa;
                            if (!is_div) begin
                                iter_start = 1'b1;
                                state_d    = ST_MUL;
                            end else if (b_is_zero) begin
                                result_d = f3[1] ? a : {XLEN{1'b1}};
                                state_d  = ST_DONE;
                            end else if (div_ovf) begin
                                result_d = f3[1] ? {XLEN{1'b0}} : a;
                                state_d  = ST_DONE;
                            end else begin
                                iter_start = 1'b1;
                                state_d    = ST_DIV;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (iter_last) begin
                        result_d = mul_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (iter_last) begin
                        result_d = div_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            f3_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            f3_q     <= f3_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign op_err    = err_q;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Directed self-checking bench for alu_exec_unit (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            flush     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [4:0]      op        = '0;
    logic [XLEN-1:0] a         = '0;
    logic [XLEN-1:0] b         = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            op_err;

    int checks = 0;
    int errors = 0;

    // Op encodings
    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SRA  = 5'b00011;
    localparam logic [4:0] OP_BAD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_SLTU = 5'b01111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    alu_exec_unit #(
        .XLEN     (XLEN),
        .ENABLE_M (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready high, scramble operands after accept,
    // measure latency and check the result, then complete the handshake.
    task automatic do_op(input string tag, input logic [4:0] o,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_res, input int exp_lat,
                         input logic exp_err);
        int   lat;
        logic ready_seen;
        op = o; a = va; b = vb; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            tick;
            lat++;
        end
        check({tag, "/latency"},  32'(lat), 32'(exp_lat));
        check({tag, "/result"},   result, exp_res);
        check({tag, "/zero"},     {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        check({tag, "/op_err"},   {31'd0, op_err}, {31'd0, exp_err});
        check({tag, "/busy_rdy"}, {31'd0, ready_seen | in_ready}, 32'd0);
        tick;
        check({tag, "/post_vld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "/post_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic seen;

        // ---------------- reset ----------------
        repeat (3) tick;
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/result",    result, 32'd0);
        check("rst/zero",      {31'd0, zero}, 32'd1);
        check("rst/op_err",    {31'd0, op_err}, 32'd0);
        rst_n = 1'b1;
        tick;
        check("rst/in_ready",  {31'd0, in_ready}, 32'd1);

        // ---------------- base ops ----------------
        do_op("ADD",   OP_ADD,  32'd5,          32'd7,          32'd12,         1, 1'b0);
        do_op("SUB",   OP_SUB,  32'd7,          32'd7,          32'd0,          1, 1'b0);
        do_op("SRA",   OP_SRA,  32'h8000_0000,  32'h0000_0021,  32'hC000_0000,  1, 1'b0);
        do_op("SLTU",  OP_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,          1, 1'b0);
        do_op("SLT",   OP_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,          1, 1'b0);
        do_op("AND",   OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1, 1'b0);
        do_op("OR",    OP_OR,   32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01,  1, 1'b0);
        do_op("XOR",   OP_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1, 1'b0);
        do_op("SLL",   OP_SLL,  32'd1,          32'h0000_0024,  32'h0000_0010,  1, 1'b0);
        do_op("SRL",   OP_SRL,  32'h8000_0000,  32'd31,         32'd1,          1, 1'b0);
        do_op("BADOP", OP_BAD,  32'd9,          32'd9,          32'd0,          1, 1'b1);

        // ---------------- multiply ----------------
        do_op("MULH",   OP_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33, 1'b0);
        do_op("MUL",    OP_MUL,    32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 33, 1'b0);
        do_op("MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        do_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);

        // ---------------- divide ----------------
        do_op("DIV",      OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        do_op("REM",      OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        do_op("DIVU",     OP_DIVU, 32'd100,       32'd7,         32'd14,        33, 1'b0);
        do_op("REMU",     OP_REMU, 32'd100,       32'd7,         32'd2,         33, 1'b0);
        do_op("DIVU0",    OP_DIVU, 32'd55,        32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        do_op("REMU0",    OP_REMU, 32'h0000_1234, 32'd0,         32'h0000_1234, 1,  1'b0);
        do_op("DIVOVF",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        do_op("REMOVF",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        op = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        tick;
        check("bp/first_vld", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            op = OP_SUB; a = 32'd100; b = 32'd1; in_valid = 1'b1;
            tick;
            check("bp/hold_vld",    {31'd0, out_valid}, 32'd1);
            check("bp/hold_result", result, 32'd7);
            check("bp/hold_rdy",    {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp/rel_vld", {31'd0, out_valid}, 32'd0);
        check("bp/rel_rdy", {31'd0, in_ready}, 32'd1);
        do_op("bp/ADD", OP_ADD, 32'd10, 32'd20, 32'd30, 1, 1'b0);

        // ---------------- flush mid-divide ----------------
        op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fl/vld",    {31'd0, out_valid}, 32'd0);
        check("fl/rdy",    {31'd0, in_ready}, 32'd1);
        check("fl/result", result, 32'd30);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("fl/no_late_vld", {31'd0, seen}, 32'd0);

        // flush together with a request in IDLE: request dropped
        flush = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("flreq/vld",    {31'd0, out_valid}, 32'd0);
        check("flreq/rdy",    {31'd0, in_ready}, 32'd1);
        check("flreq/result", result, 32'd30);
        tick;
        check("flreq/vld2",   {31'd0, out_valid}, 32'd0);
        do_op("fl/ADD", OP_ADD, 32'd2, 32'd2, 32'd4, 1, 1'b0);

        // ---------------- async reset mid-multiply ----------------
        op = OP_MUL; a = 32'd5; b = 32'd6; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst/vld",    {31'd0, out_valid}, 32'd0);
        check("arst/result", result, 32'd0);
        check("arst/zero",   {31'd0, zero}, 32'd1);
        check("arst/op_err", {31'd0, op_err}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        check("arst/rdy", {31'd0, in_ready}, 32'd1);
        do_op("arst/MUL", OP_MUL, 32'd5, 32'd6, 32'd30, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute stage: base RV32I/RV64I integer ops plus RV-M multiply/divide.
- Takes the 4-bit ALU control code produced by the ALU decoder, extended to a 5-bit op.
- Base ops finish in one cycle; MUL*/DIV*/REM* run iteratively.
- valid/ready handshakes on both sides; sits between the decode/regfile read and writeback.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- ENABLE_M, 1, 1 = implement M-extension ops; 0 = M ops return 0 with op_err.
- SHAMT_W, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: drop in-flight op and any held result.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  5  op[4]=0: op[3:0] is the base ALU code; op[4]=1: op[2:0] is the M funct3.
- a  in  XLEN  operand rs1.
- b  in  XLEN  operand rs2 or immediate.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0 (branch compare).
- op_err  out  1  undefined op code, or M op with ENABLE_M=0.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, result=0, zero=1, op_err=0, in_ready=1 once released.
- Base codes: AND 0000, OR 0001, ADD 0010, SRA 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, XOR 1010, SLTU 1111.
  - Any other base code: result=0, op_err=1.
- Shifts use b[SHAMT_W-1:0] only. SLT/SLTU produce 0 or 1, zero-extended.
- M funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On accept (in_valid & in_ready):
    - Base op: go to DONE; out_valid rises on the next cycle (latency 1).
    - MUL*: latch operands as magnitudes plus a sign flag, go to MUL.
    - DIV*/REM*: latch operands as magnitudes plus a sign flag, go to DIV.
  - MUL: radix-2 shift-add, 2*XLEN-bit accumulator, XLEN iterations.
    - Apply the sign, select the low (MUL) or high (MULH*) half, go to DONE. Latency XLEN+1.
  - DIV: restoring division, XLEN iterations, then sign fixup (quotient sign = sa^sb, remainder sign = sa), go to DONE. Latency XLEN+1.
  - DONE: out_valid=1. result, zero and op_err stay stable until out_ready.
    - On out_ready, go to IDLE; in_ready rises in the same cycle.
    - No result bypass: back-to-back base ops give one result every 2 cycles.
- Divide fast paths (go straight to DONE, latency 1):
  - b==0: DIV/DIVU give all-ones, REM/REMU give a.
  - Signed overflow (a = most negative, b = -1): DIV gives a, REM gives 0.
- in_ready=0 in MUL, DIV and DONE. in_valid while not ready is ignored and not queued.
- flush has priority over everything except reset. Next state is IDLE, out_valid=0, iteration counter cleared, result keeps its value.
  - flush together with in_valid in IDLE: request is not accepted.
- Iteration counter is $clog2(XLEN)+1 bits. Counter terminal value equals XLEN; no wrap.
- Operands are captured at accept. Changes on a/b during iteration have no effect.

Decomposition:
- Shared package alu_pkg: base ALU code constants (the ten values above), M funct3 constants, state enum, op-field widths.
- One sub-module: alu_muldiv_iter, holding the shared accumulator/shift-register datapath for MUL and DIV, with start/done.
- Base ALU logic and the FSM stay in alu_exec_unit.

Test Plan:
- Reset then ADD a=5, b=7, XLEN=32 -> out_valid the cycle after accept, result=12, zero=0. SUB 7-7 -> result=0, zero=1.
- SRA a=0x80000000, b=0x21 -> shift 1 -> result=0xC0000000. SLTU a=1, b=0xFFFFFFFF -> 1. SLT same operands -> 0.
- MULH a=-2, b=3 -> result=0xFFFFFFFF after 33 cycles. MUL same operands -> 0xFFFFFFFA. in_ready=0 throughout.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU b=0 -> 0xFFFFFFFF in 1 cycle. DIV 0x80000000 / -1 -> 0x80000000. REM of the same -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result stable, in_ready=0. Release -> handshake, then a new accept.
- flush at iteration 10 of DIVU -> next cycle IDLE, out_valid stays 0, a new ADD is accepted and completes correctly. Assert rst_n low mid-MUL -> outputs return to reset values immediately.
